// File: rtl/booth_mac_seq.sv
// Iterative radix-2 Booth signed multiplier with a saturating accumulator.
// One Booth step is retired per clock; start/ready/done handshake.
module booth_mac_seq #(
    parameter int WIDTH     = 8,
    parameter int ACC_GUARD = 8,
    localparam int ACC_WIDTH = 2*WIDTH + ACC_GUARD
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 acc_en,
    input  logic                 acc_clr,
    input  logic [WIDTH-1:0]     w2mul,
    input  logic [WIDTH-1:0]     x2mul,
    output logic                 ready,
    output logic                 done,
    output logic [2*WIDTH-1:0]   mul2acc,
    output logic [ACC_WIDTH-1:0] acc_out,
    output logic                 ovf
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t               state_reg, state_next;
    logic                 load, step, fin;

    logic [WIDTH-1:0]     m_reg;
    logic [WIDTH:0]       a_reg;
    logic [WIDTH-1:0]     q_reg;
    logic                 qm1_reg;
    logic [CNT_W-1:0]     cnt_reg;
    logic                 acc_en_reg, acc_clr_reg;
    logic [2*WIDTH-1:0]   mul2acc_reg;
    logic [ACC_WIDTH-1:0] acc_reg;
    logic                 ovf_reg;
    logic                 done_reg;

    logic [WIDTH:0]       m_ext;
    logic [WIDTH:0]       a_sum;
    logic [2*WIDTH-1:0]   product;
    logic [ACC_WIDTH-1:0] prod_ext;
    logic [ACC_WIDTH:0]   acc_sum;
    logic                 acc_of;
    logic [ACC_WIDTH-1:0] acc_sat;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= IDLE;
        else      state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        step       = 1'b0;
        fin        = 1'b0;
        case (state_reg)
            IDLE: if (start) begin
                load       = 1'b1;
                state_next = CALC;
            end
            CALC: begin
                step = 1'b1;
                if (cnt_reg == CNT_W'(WIDTH-1)) state_next = FIN;
            end
            FIN: begin
                fin        = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // A carries one extra bit so that subtracting -2^(W-1) cannot wrap.
    assign m_ext = {m_reg[WIDTH-1], m_reg};

    always_comb begin
        a_sum = a_reg;
        case ({q_reg[0], qm1_reg})
            2'b01:   a_sum = a_reg + m_ext;
            2'b10:   a_sum = a_reg - m_ext;
            default: a_sum = a_reg;
        endcase
    end

    assign product  = {a_reg[WIDTH-1:0], q_reg};
    assign prod_ext = ACC_WIDTH'($signed(product));
    assign acc_sum  = {acc_reg[ACC_WIDTH-1], acc_reg} + {prod_ext[ACC_WIDTH-1], prod_ext};
    assign acc_of   = acc_sum[ACC_WIDTH] ^ acc_sum[ACC_WIDTH-1];
    // On overflow the extra top bit holds the true sign: clamp toward it.
    assign acc_sat  = acc_of ? {acc_sum[ACC_WIDTH], {(ACC_WIDTH-1){~acc_sum[ACC_WIDTH]}}}
                             : acc_sum[ACC_WIDTH-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_reg       <= '0;
            a_reg       <= '0;
            q_reg       <= '0;
            qm1_reg     <= 1'b0;
            cnt_reg     <= '0;
            acc_en_reg  <= 1'b0;
            acc_clr_reg <= 1'b0;
            mul2acc_reg <= '0;
            acc_reg     <= '0;
            ovf_reg     <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (load) begin
                m_reg       <= w2mul;
                q_reg       <= x2mul;
                qm1_reg     <= 1'b0;
                a_reg       <= '0;
                cnt_reg     <= '0;
                acc_en_reg  <= acc_en;
                acc_clr_reg <= acc_clr;
            end
            if (step) begin
                a_reg   <= {a_sum[WIDTH], a_sum[WIDTH:1]};
                q_reg   <= {a_sum[0], q_reg[WIDTH-1:1]};
                qm1_reg <= q_reg[0];
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
            if (fin) begin
                mul2acc_reg <= product;
                done_reg    <= 1'b1;
                if (acc_clr_reg) begin
                    acc_reg <= prod_ext;
                    ovf_reg <= 1'b0;
                end else if (acc_en_reg) begin
                    acc_reg <= acc_sat;
                    if (acc_of) ovf_reg <= 1'b1;
                end
            end
        end
    end

    assign ready   = (state_reg == IDLE);
    assign done    = done_reg;
    assign mul2acc = mul2acc_reg;
    assign acc_out = acc_reg;
    assign ovf     = ovf_reg;

endmodule

// File: tb/tb_booth_mac_seq.sv
// Randomised scoreboard bench for booth_mac_seq (WIDTH=8, ACC_GUARD=0 so that
// accumulator saturation is reached often).
module tb_booth_mac_seq;

    localparam int W     = 8;
    localparam int G     = 0;
    localparam int ACC_W = 2*W + G;
    localparam longint AMAX = (64'sd1 <<< (ACC_W-1)) - 1;
    localparam longint AMIN = -(64'sd1 <<< (ACC_W-1));

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               start = 1'b0;
    logic               acc_en = 1'b0;
    logic               acc_clr = 1'b0;
    logic [W-1:0]       w2mul = '0;
    logic [W-1:0]       x2mul = '0;
    logic               ready, done, ovf;
    logic [2*W-1:0]     mul2acc;
    logic [ACC_W-1:0]   acc_out;

    booth_mac_seq #(.WIDTH(W), .ACC_GUARD(G)) dut (
        .clk(clk), .rst(rst), .start(start), .acc_en(acc_en), .acc_clr(acc_clr),
        .w2mul(w2mul), .x2mul(x2mul), .ready(ready), .done(done),
        .mul2acc(mul2acc), .acc_out(acc_out), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        longint prod;
        longint acc;
        bit     ovf;
        int     done_at;
    } exp_t;

    exp_t   sb[$];
    int     n_vec = 0;
    int     n_bad = 0;
    longint m_acc = 0;
    bit     m_ovf = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer product and clamped accumulation.
    task automatic model_push(input int w, input int x, input bit en, input bit clr, input int acc_edge);
        exp_t   e;
        longint p, s;
        p = longint'(w) * longint'(x);
        if (clr) begin
            m_acc = p;
            m_ovf = 1'b0;
        end else if (en) begin
            s = m_acc + p;
            if (s > AMAX) begin s = AMAX; m_ovf = 1'b1; end
            else if (s < AMIN) begin s = AMIN; m_ovf = 1'b1; end
            m_acc = s;
        end
        e.prod = p; e.acc = m_acc; e.ovf = m_ovf; e.done_at = acc_edge + W + 1;
        sb.push_back(e);
    endtask

    // Monitor: every done pulse must match the oldest outstanding op.
    always @(negedge clk) begin
        if (rst && done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("latency", cyc, e.done_at);
                chk("mul2acc", longint'($signed(mul2acc)), e.prod);
                chk("acc_out", longint'($signed(acc_out)), e.acc);
                chk("ovf", ovf, e.ovf);
                $display("op done: prod=%0d acc=%0d ovf=%0b", $signed(mul2acc), $signed(acc_out), ovf);
            end
        end
    end

    // Called at a falling edge with ready=1; returns at the falling edge after
    // the FIN edge, when the next start may be presented back-to-back.
    task automatic do_op(input int w, input int x, input bit en, input bit clr, input bit noise);
        int acc_edge;
        int busy_bad;
        w2mul = W'(w); x2mul = W'(x); acc_en = en; acc_clr = clr; start = 1'b1;
        @(posedge clk); #1;
        acc_edge = cyc;
        start = 1'b0;
        model_push(w, x, en, clr, acc_edge);
        busy_bad = 0;
        for (int i = 0; i <= W; i++) begin
            @(negedge clk);
            if (ready !== 1'b0) busy_bad++;
            if (noise) begin
                start = 1'($urandom); w2mul = W'($urandom); x2mul = W'($urandom);
                acc_en = 1'($urandom); acc_clr = 1'($urandom);
            end
        end
        chk("busy_ready", busy_bad, 0);
        @(negedge clk);
        start = 1'b0;
        chk("ready_back", ready, 1);
    endtask

    function automatic int pick();
        int sel;
        sel = int'($urandom_range(0, 5));
        case (sel)
            0: return -128;
            1: return 127;
            2: return 0;
            3: return -1;
            default: return int'($urandom_range(0, 255)) - 128;
        endcase
    endfunction

    initial begin
        int wait_cnt;
        // Reset state
        #12;
        chk("rst_ready", ready, 1);
        chk("rst_done", done, 0);
        chk("rst_mul", mul2acc, 0);
        chk("rst_acc", acc_out, 0);
        chk("rst_ovf", ovf, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Directed: -5*8 with clear, then back-to-back 7*7 accumulate
        do_op(8, -5, 1'b0, 1'b1, 1'b0);
        chk("dir_mul_raw", mul2acc, 16'hFFD8);
        chk("dir_acc", longint'($signed(acc_out)), -40);
        do_op(7, 7, 1'b1, 1'b0, 1'b0);
        chk("dir_mul2", mul2acc, 49);
        chk("dir_acc2", longint'($signed(acc_out)), 9);
        chk("dir_ovf2", ovf, 0);

        // Corners and saturation (accumulator is exactly 16 bits here)
        do_op(-128, -128, 1'b0, 1'b1, 1'b0);
        do_op(-128, -128, 1'b1, 1'b0, 1'b0);
        chk("sat_acc", longint'($signed(acc_out)), 32767);
        chk("sat_ovf", ovf, 1);
        do_op(-128, -128, 1'b0, 1'b1, 1'b0);
        chk("clr_acc", longint'($signed(acc_out)), 16384);
        chk("clr_ovf", ovf, 0);
        do_op(127, -128, 1'b0, 1'b1, 1'b0);
        chk("corner_mul", longint'($signed(mul2acc)), -16256);
        do_op(0, -1, 1'b1, 1'b0, 1'b0);
        chk("zero_mul", mul2acc, 0);

        // Randomised ops, with start/operand noise while busy
        for (int n = 0; n < 1500; n++) begin
            do_op(pick(), pick(), 1'($urandom), ($urandom_range(0, 7) == 0), 1'($urandom));
        end

        // Reset in the middle of CALC aborts the op
        w2mul = W'(100); x2mul = W'(-77); acc_en = 1'b1; acc_clr = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("abort_ready", ready, 1);
        chk("abort_done", done, 0);
        chk("abort_mul", mul2acc, 0);
        chk("abort_acc", acc_out, 0);
        chk("abort_ovf", ovf, 0);
        m_acc = 0;
        m_ovf = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        do_op(3, 3, 1'b0, 1'b0, 1'b0);
        chk("post_rst_mul", mul2acc, 9);

        // Drain the scoreboard with a bounded wait
        wait_cnt = 0;
        while (sb.size() != 0 && wait_cnt < 40) begin
            @(negedge clk);
            wait_cnt++;
        end
        chk("drain", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/booth_mac_seq.md
Name: booth_mac_seq

Overview:
- Iterative radix-2 Booth signed multiplier with an integrated saturating accumulator and a start/ready/done handshake.
- Parametrised successor to the fixed 8-bit booth multiplier feeding the ALU accumulate path: width is generic, operands are captured at start, and one Booth step is retired per clock.
- Sits between operand registers (w/x) and the ALU result/accumulator path.

Parameters:
- WIDTH, 8, operand width in bits (signed two's complement, WIDTH >= 2).
- ACC_GUARD, 8, extra accumulator bits above the product; ACC_WIDTH = 2*WIDTH + ACC_GUARD.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request a multiply; accepted only when ready=1.
- acc_en  input  1  sampled with start; 1 = add product into accumulator.
- acc_clr  input  1  sampled with start; 1 = accumulator loads product (overrides acc_en), clears ovf.
- w2mul  input  WIDTH  signed multiplicand, sampled on the accepted start.
- x2mul  input  WIDTH  signed multiplier, sampled on the accepted start.
- ready  output  1  high in IDLE.
- done  output  1  one-cycle pulse: mul2acc/acc_out updated.
- mul2acc  output  2*WIDTH  signed product of last operation (held).
- acc_out  output  ACC_WIDTH  signed accumulator (held).
- ovf  output  1  sticky accumulator saturation flag.

Behaviour:
- Reset (rst=0, async): state IDLE, ready=1, done=0, mul2acc=0, acc_out=0, ovf=0, internal regs 0. Reset mid-operation aborts with no output update.
- FSM IDLE -> CALC -> FIN -> IDLE.
- IDLE: on an edge with start=1, capture M=w2mul, Q=x2mul, q_m1=0, A=0 (WIDTH+1 bits), cnt=0, and latch acc_en/acc_clr. Go to CALC.
- CALC, one Booth step per edge:
  - {Q[0],q_m1}=01: A += sext(M).
  - 10: A -= sext(M).
  - 00/11: no-op.
  - Then arithmetic right shift of {A,Q,q_m1} by 1.
  - cnt increments; after WIDTH steps go to FIN.
- A is WIDTH+1 bits so -2^(W-1) * -2^(W-1) is exact. Product = {A[W-1:0],Q}.
- FIN edge:
  - mul2acc <= product.
  - Accumulator:
    - if acc_clr: acc_out <= sext(product), ovf <= 0.
    - else if acc_en: acc_out <= sat(acc_out + sext(product)).
    - else: unchanged.
  - done <= 1; state IDLE.
- Saturation: on signed overflow, clamp to +2^(ACC_W-1)-1 or -2^(ACC_W-1) and set ovf=1. ovf clears only via acc_clr or reset.
- Latency: start accepted at edge N; outputs and done valid after edge N+WIDTH+1.
- done is high for exactly one cycle. ready rises in that same cycle, so the next start can be accepted at edge N+WIDTH+2 (throughput one op per WIDTH+2 cycles).
- start while ready=0 is ignored (not queued).
- Operand, acc_en and acc_clr changes after acceptance have no effect.
- mul2acc and acc_out are stable except on the FIN edge.

Test Plan:
- WIDTH=8: x2mul=-5, w2mul=8, acc_clr=1, start at edge N -> done only after edge N+9, mul2acc=16'hFFD8 (-40), acc_out=-40, ready low for edges N+1..N+9.
- Follow-up back-to-back start at edge N+10: 7*7 with acc_en=1 -> mul2acc=49, acc_out=9, ovf=0.
- Corners: (-128)*(-128) -> 16384; 127*(-128) -> -16256; 0*(-1) -> 0. Sweep all 65536 pairs against a reference model.
- ACC_GUARD=0: (-128)*(-128) with acc_clr, then the same with acc_en -> acc_out=32767, ovf=1. A third op with acc_clr -> ovf=0, acc_out=16384.
- start pulsed and operands changed during CALC -> ignored; result matches the originally captured operands; exactly one done.
- Assert rst=0 at CALC step 4 -> all outputs 0 immediately (async), ready=1, no done. A fresh 3*3 op after release -> 9.
